// File: rtl/branch_update_arbiter.sv
// branch_update_arbiter: sequences the branch predictor table update port.
// After reset or flush it sweeps every table index writing "not taken", then
// arbitrates two branch resolvers round-robin into a small update FIFO that
// drains one entry per cycle into the predictor.
// Optional feature macro: PRED_STATS_EN adds a saturating mispredict counter.
module branch_update_arbiter #(
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          req0_valid,
  input  logic [ADDR_W-1:0]             req0_addr,
  input  logic                          req0_taken,
  input  logic                          req0_pred,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [ADDR_W-1:0]             req1_addr,
  input  logic                          req1_taken,
  input  logic                          req1_pred,
  output logic                          req1_ready,
  output logic                          upd_valid,
  output logic [ADDR_W-1:0]             upd_addr,
  output logic                          upd_result,
  input  logic                          upd_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef PRED_STATS_EN
  ,output logic [CNT_W-1:0]             mispredict_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] sweep_idx;
  logic              last_grant;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
  logic              fifo_taken [FIFO_DEPTH];

  logic              full;
  logic              empty;
  logic              can_grant;
  logic              grant0;
  logic              grant1;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_addr;
  logic              push_taken;

  assign full       = (count == FULL_COUNT);
  assign empty      = (count == '0);
  assign fifo_count = count;
  assign busy       = (state == INIT);

  // Round-robin grant: a lone requester wins, ties go away from last_grant
  always_comb begin
    can_grant  = (state == RUN) && !flush && !full;
    grant0     = can_grant && req0_valid && (!req1_valid || last_grant);
    grant1     = can_grant && req1_valid && (!req0_valid || !last_grant);
    push       = grant0 || grant1;
    push_addr  = grant0 ? req0_addr  : req1_addr;
    push_taken = grant0 ? req0_taken : req1_taken;
    pop        = (state == RUN) && !empty && upd_ready;
    req0_ready = grant0;
    req1_ready = grant1;
  end

  // Update port shows the sweep write during INIT and the FIFO head in RUN
  always_comb begin
    if (state == INIT) begin
      upd_valid  = 1'b1;
      upd_addr   = sweep_idx;
      upd_result = 1'b0;
    end else begin
      upd_valid  = !empty;
      upd_addr   = fifo_addr[rd_ptr];
      upd_result = fifo_taken[rd_ptr];
    end
  end

  // FSM, sweep index, FIFO pointers/occupancy and round-robin history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= INIT;
      sweep_idx  <= '0;
      last_grant <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else if (flush) begin
      state     <= INIT;
      sweep_idx <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      case (state)
        INIT: begin
          if (upd_ready) begin
            if (sweep_idx == LAST_IDX) begin
              state     <= RUN;
              sweep_idx <= '0;
            end else begin
              sweep_idx <= sweep_idx + 1'b1;
            end
          end
        end
        RUN: begin
          if (push) begin
            wr_ptr     <= wr_ptr + 1'b1;
            last_grant <= grant1;
          end
          if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
          end
          if (push && !pop) begin
            count <= count + 1'b1;
          end else if (pop && !push) begin
            count <= count - 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // FIFO storage is written only on a grant, so it needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= push_addr;
      fifo_taken[wr_ptr] <= push_taken;
    end
  end

`ifdef PRED_STATS_EN
  logic mispredicted;

  assign mispredicted = (grant0 && (req0_taken != req0_pred)) ||
                        (grant1 && (req1_taken != req1_pred));

  // Saturating count of granted branches whose outcome differed from prediction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mispredict_count <= '0;
    end else if (flush) begin
      mispredict_count <= '0;
    end else if (mispredicted && (mispredict_count != '1)) begin
      mispredict_count <= mispredict_count + 1'b1;
    end
  end
`else
  logic unused_pred;

  assign unused_pred = ^{req0_pred, req1_pred, {CNT_W{1'b0}}};
`endif

endmodule

// File: doc/branch_update_arbiter.md
# branch_update_arbiter

Controller that sequences the write/update port of the branch predictor table and shares it between two branch-resolution requesters. Requests are arbitrated round-robin into a small update FIFO that drains one entry per cycle into the predictor's update port. After reset or an explicit flush, the block first walks every table address and writes "not taken" before accepting any requester traffic. It sits between the execute-stage branch resolvers and the predictor table.

## Interface
- ADDR_W, 4, predictor table index width; table holds 2^ADDR_W entries
- FIFO_DEPTH, 4, update FIFO depth; power of two, at least 2
- CNT_W, 16, mispredict counter width (used only with PRED_STATS_EN)

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous reset, active-low
- flush  in  1  request table re-initialisation; sampled in any state
- req0_valid  in  1  requester 0 has a resolved branch
- req0_addr  in  ADDR_W  requester 0 table index
- req0_taken  in  1  requester 0 actual branch outcome
- req0_pred  in  1  requester 0 prediction made at fetch
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid, req1_addr, req1_taken, req1_pred, req1_ready  (same widths and meanings for requester 1)
- upd_valid  out  1  update presented to predictor
- upd_addr  out  ADDR_W  update index
- upd_result  out  1  value to write (branch outcome)
- upd_ready  in  1  predictor accepts the update this cycle
- busy  out  1  high while in INIT
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- mispredict_count  out  CNT_W  present only with PRED_STATS_EN

## Operation
- FSM states: INIT, RUN.
- Reset (rst low) forces: state INIT, sweep index 0, FIFO empty, last_grant 1 (requester 0 wins first), mispredict_count 0.
- INIT:
  - upd_valid=1, upd_addr=sweep index, upd_result=0.
  - Index increments on each upd_ready.
  - When index 2^ADDR_W-1 is accepted, the next state is RUN with index cleared.
  - req0_ready=req1_ready=0; busy=1; FIFO is held empty.
- RUN:
  - busy=0.
  - Grant is computed combinationally. The grant goes to the sole valid requester. If both are valid, it goes to the requester not equal to last_grant.
  - A grant is blocked when the FIFO is full or flush=1.
  - reqN_ready = grantN. ready depends on valid; requesters must not make valid depend on ready.
  - On a grant, {addr, taken} is pushed and last_grant is updated. last_grant is unchanged when there is no grant.
  - FIFO head drives upd_valid (= not empty), upd_addr, and upd_result (= head taken). Pop occurs on upd_valid && upd_ready.
  - Push and pop in the same cycle are both performed; fifo_count is unchanged. Full blocks a push even if a pop occurs that cycle.
  - Pointers wrap modulo FIFO_DEPTH; fifo_count saturates neither way (full/empty logic prevents overflow).
- flush=1 in any state, at the next edge:
  - FIFO is discarded (count 0, pointers 0) and the state becomes INIT with index 0.
  - A flush during INIT restarts the sweep.
  - Any in-flight upd handshake that same cycle still completes on the predictor side, but its entry is discarded.

## Timing
- Push at edge N makes the entry visible on upd_valid after edge N when the FIFO was empty. Request-to-update latency is 1 cycle.
- Sustained throughput is one update per cycle with upd_ready held high.
- INIT lasts exactly 2^ADDR_W cycles with upd_ready held high. It is then followed by RUN; req ready may assert in the first RUN cycle.
- All outputs except the reqN_ready/grant path are register-driven or FIFO-head-driven.
- Output values in reset: upd_valid=1, upd_addr=0, upd_result=0, busy=1, fifo_count=0, reqN_ready=0.

## Configuration
- PRED_STATS_EN defined: mispredict_count port exists.
  - Increments by 1 per granted request with taken != pred.
  - Saturates at all-ones.
  - Cleared by reset and flush.
- PRED_STATS_EN undefined: port and counter are absent; reqN_pred inputs are ignored.

## Test plan
- Reset, upd_ready=1: exactly 16 updates with addr 0..15 and result 0, with busy=1. Then busy=0 and no upd_valid until a request arrives.
- RUN, req0 only (addr 3, taken 1): req0_ready=1 that cycle. Next cycle upd_valid=1, upd_addr=3, upd_result=1, fifo_count=1 then 0.
- Both requesters valid continuously, upd_ready=1: grants alternate 0,1,0,1 starting with req0; fifo_count stays at most 1.
- upd_ready=0, both valid: 4 grants, then fifo_count=4 and both ready=0. Raising upd_ready drains in order; a new grant resumes with one pending push/pop pair and the count holds.
- FIFO holding 3 entries, pulse flush: next cycle fifo_count=0, busy=1, upd_addr=0. Flushing mid-INIT at index 9 restarts at 0.
- PRED_STATS_EN: 5 granted requests with 3 where taken != pred gives mispredict_count=3. Flush gives 0. Driving 2^CNT_W+2 mispredicts leaves the counter at all-ones.
